// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-write-side signals shared by fifo_wr_arbiter.
// master drives requests and FIFO flags; slave is the arbiter itself.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  awfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       grant;
    logic                  busy;

    modport master (
        output req_valid, req_data, req_last, wfull, awfull,
        input  req_ready, winc, wdata, grant, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, wfull, awfull,
        output req_ready, winc, wdata, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Optional macro WR_ARB_AWFULL_THROTTLE_EN: hold off new grants while awfull is set.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
) (
    input logic             wclk,
    input logic             wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state, state_next;
    logic [NREQ-1:0] grant_q, grant_next;
    logic [IW-1:0]   owner, owner_next;
    logic [IW-1:0]   rr_ptr, rr_next;
    logic [IW-1:0]   pick;
    logic            pick_found;
    logic            arb_ok;
    logic            beat;
    logic [NREQ-1:0] ready_c;
    logic            winc_c;
    logic [DSIZE-1:0] wdata_c;

    // Round-robin search starting just after the last packet owner.
    always_comb begin
        int idx;
        logic [IW-1:0] cand;
        idx        = 0;
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(rr_ptr) + k) % NREQ;
            cand = IW'(idx);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

`ifdef WR_ARB_AWFULL_THROTTLE_EN
    assign arb_ok = pick_found & ~bus.wfull & ~bus.awfull;
`else
    logic unused_awfull;
    assign unused_awfull = bus.awfull;
    assign arb_ok = pick_found & ~bus.wfull;
`endif

    assign beat = (state == LOCK) & bus.req_valid[owner] & ~bus.wfull;

    always_comb begin
        state_next = state;
        grant_next = grant_q;
        owner_next = owner;
        rr_next    = rr_ptr;
        ready_c    = '0;
        winc_c     = 1'b0;
        wdata_c    = '0;
        case (state)
            IDLE: begin
                if (arb_ok) begin
                    state_next       = LOCK;
                    owner_next       = pick;
                    grant_next       = '0;
                    grant_next[pick] = 1'b1;
                end
            end
            LOCK: begin
                if (beat && bus.req_last[owner]) begin
                    state_next = IDLE;
                    grant_next = '0;
                    rr_next    = owner;
                end
                // Reset gates the beat combinationally so an abandoned packet never writes.
                if (!wrst) begin
                    ready_c[owner] = ~bus.wfull;
                    winc_c         = beat;
                    if (beat) begin
                        wdata_c = bus.req_data[owner*DSIZE +: DSIZE];
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state   <= IDLE;
            grant_q <= '0;
            owner   <= '0;
            rr_ptr  <= IW'(NREQ - 1);
        end else begin
            state   <= state_next;
            grant_q <= grant_next;
            owner   <= owner_next;
            rr_ptr  <= rr_next;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.winc      = winc_c;
    assign bus.wdata     = wdata_c;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state == LOCK);
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the FIFO write port (2..8).
REQ-002 Parameter DSIZE, default 8, SHALL set the data width of each requester and of the FIFO write data.
REQ-003 Port wclk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 Port wrst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 Port req_valid  in  NREQ  SHALL carry the per-requester data valid.
REQ-006 Port req_data  in  NREQ*DSIZE  SHALL carry the per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-007 Port req_last  in  NREQ  SHALL mark the final beat of a requester's packet.
REQ-008 Port req_ready  out  NREQ  SHALL be the per-requester beat-accept signal.
REQ-009 Port wfull  in  1  SHALL be the registered FIFO full flag in the wclk domain.
REQ-010 Port awfull  in  1  SHALL be the registered FIFO almost-full flag.
REQ-011 Port winc  out  1  SHALL be the FIFO write strobe.
REQ-012 Port wdata  out  DSIZE  SHALL be the FIFO write data.
REQ-013 Port grant  out  NREQ  SHALL be the registered one-hot owner, or all zeros when idle.
REQ-014 Port busy  out  1  SHALL be high while a packet holds the write port.

Function
REQ-015 The FSM SHALL have two states: IDLE and LOCK.
REQ-016 In IDLE, if any req_valid bit is set and wfull=0, the block SHALL register grant to the first valid requester, searching round-robin from rr_ptr+1 modulo NREQ, and move to LOCK on the next edge.
REQ-017 No beat SHALL transfer in IDLE: req_ready=0 and winc=0, giving one arbitration bubble per packet.
REQ-018 In LOCK with owner g, the block SHALL drive req_ready[g]=~wfull, all other req_ready bits =0, winc=req_valid[g]&~wfull, and wdata=req_data[g]; these are combinational from registered state.
REQ-019 winc SHALL never be asserted while wfull=1.
REQ-020 A beat SHALL be accepted when req_valid[g]&req_ready[g]; on an accepted beat with req_last[g]=1 the block SHALL return to IDLE, set rr_ptr=g and clear grant.
REQ-021 Ownership SHALL persist across wfull stalls and across owner valid gaps; there is no timeout.
REQ-022 Round-robin wrap SHALL go from index NREQ-1 to index 0.
REQ-023 A single-beat packet (last on the first beat) SHALL occupy exactly 2 cycles: arbitration plus transfer.
REQ-024 A requester's next packet SHALL NOT be granted before every other waiting requester has been granted once.
REQ-025 wdata SHALL be zero when winc=0.

Reset
REQ-026 While wrst=1 the block SHALL hold state IDLE, grant=0, busy=0, winc=0, req_ready=0, wdata=0, and rr_ptr=NREQ-1, so requester 0 has first priority.
REQ-027 Reset asserted mid-packet SHALL abandon the packet immediately; no winc SHALL occur in the reset cycle or after it until a new grant.

Configuration
REQ-028 With macro WR_ARB_AWFULL_THROTTLE_EN defined, IDLE SHALL also require awfull=0 before granting, and packets already in LOCK SHALL continue regardless of awfull.
REQ-029 Without WR_ARB_AWFULL_THROTTLE_EN, awfull SHALL be ignored.

Verification
REQ-030 NREQ=4. After reset, assert req_valid=4'b1111 with one-beat packets -> grants occur in order 0,1,2,3,0 and winc is high every second cycle.
REQ-031 Requester 2 sends a 3-beat packet (0xA1,0xA2,0xA3) while requester 0 is valid -> wdata shows A1,A2,A3 contiguously, then requester 0 is granted after the 1-cycle bubble.
REQ-032 Raise wfull=1 during beat 2 of a 3-beat packet for 5 cycles -> winc=0 and req_ready=0 for those 5 cycles, grant is unchanged, and the transfer resumes with the same data.
REQ-033 Assert wrst for 1 cycle mid-packet -> the next cycle shows grant=0, busy=0, winc=0, and the next grant goes to requester 0.
REQ-034 With WR_ARB_AWFULL_THROTTLE_EN defined and awfull=1 in IDLE with requester 1 valid -> no grant is issued; deassert awfull -> grant=4'b0010 on the following edge.
